// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer: once-per-frame update window scheduler; define FRAME_SEQ_OVERRUN_CNT_EN for the abort counter
module vga_frame_sequencer #(
  parameter int POS_W     = 10,
  parameter int FRAME_DIV = 1,
  parameter int MAX_GRANT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixel_en,
  input  logic             vOutValid,
  input  logic             upd_req,
  input  logic             upd_done,
  input  logic [POS_W-1:0] upd_pos_in,
  output logic             frame_tick,
  output logic             upd_grant,
  output logic [POS_W-1:0] frame_pos,
  output logic             overrun,
  output logic [7:0]       overrun_cnt
);
  localparam int WD_W = $clog2(MAX_GRANT + 1);
  typedef enum logic [1:0] {ACTIVE, BLANK, GRANT, DONE} state_t;
  state_t state, state_d;
  logic v_prev, vb_start, va_start, sched, wd_exp, commit, abort, enter;
  logic [7:0] divider;
  logic [WD_W-1:0] watchdog;
  assign vb_start  = v_prev & ~vOutValid;
  assign va_start  = ~v_prev & vOutValid;
  assign sched     = vb_start & (divider == 8'(FRAME_DIV - 1));
  assign wd_exp    = pixel_en & (watchdog == WD_W'(MAX_GRANT - 1));
  assign upd_grant = state == GRANT;
  assign enter     = (state_d == GRANT) & (state != GRANT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= DONE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    commit  = 1'b0;
    abort   = 1'b0;
    case (state)
      ACTIVE: state_d = sched ? (upd_req ? GRANT : BLANK) : vb_start ? DONE : ACTIVE;
      BLANK:  state_d = va_start ? ACTIVE : upd_req ? GRANT : BLANK;
      GRANT: begin
        commit  = upd_done;
        abort   = ~upd_done & (va_start | wd_exp);
        state_d = upd_done ? DONE : va_start ? ACTIVE : wd_exp ? DONE : GRANT;
      end
      default: state_d = va_start ? ACTIVE : DONE;
    endcase
  end
  // watchdog advances only on pixel-qualified clocks while the window is open
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v_prev     <= 1'b0;
      divider    <= 8'd0;
      watchdog   <= '0;
      frame_tick <= 1'b0;
      frame_pos  <= '0;
      overrun    <= 1'b0;
    end else begin
      v_prev     <= vOutValid;
      if (vb_start) divider <= sched ? 8'd0 : divider + 8'd1;
      frame_tick <= sched & (state == ACTIVE);
      watchdog   <= enter ? '0 : (upd_grant & pixel_en) ? watchdog + WD_W'(1) : watchdog;
      if (commit) frame_pos <= upd_pos_in;
      if (abort) overrun <= 1'b1;
    end
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) overrun_cnt <= 8'd0;
    else if (abort && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
`else
  assign overrun_cnt = 8'd0;
`endif
endmodule
